// File: rtl/ff_stream_loader.sv
// ff_stream_loader: assembles a little-endian byte stream into 32-bit words,
// buffers the whole network image, then replays it to the feed-forward engine
// as one gap-free burst behind a single load pulse, issues start, and waits
// for the engine's completion flag.
module ff_stream_loader #(
  parameter int          DEPTH    = 512,
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              ff_done,
  output logic [31:0]       data,
  output logic              load,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              drop
);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_LOAD    = 3'd1,
    S_BURST   = 3'd2,
    S_START   = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [31:0]       mem_r [DEPTH];
  logic [1:0]        byte_idx_r;
  logic [23:0]       partial_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W:0]   rd_ptr_r;
  logic [ADDR_W:0]   word_count_r;
  logic              overflow_r;
  logic [31:0]       data_r;

  logic              accept_s;
  logic              word_done_s;
  logic              is_end_s;
  logic              last_slot_s;
  logic              burst_end_s;
  logic [31:0]       word_s;
  logic [ADDR_W:0]   wr_next_s;

  // Status outputs decode directly from the state register.
  assign rx_ready   = (state_r == S_COLLECT);
  assign load       = (state_r == S_LOAD);
  assign start      = (state_r == S_START);
  assign done       = (state_r == S_DONE);
  assign busy       = (state_r == S_LOAD) || (state_r == S_BURST) ||
                      (state_r == S_START) || (state_r == S_RUN);
  // A byte offered while we are not listening is reported in the same cycle.
  assign drop       = rx_valid && !rx_ready;
  assign data       = data_r;
  assign word_count = word_count_r;
  assign overflow   = overflow_r;

  assign accept_s    = rx_valid && rx_ready;
  assign word_done_s = accept_s && (byte_idx_r == 2'd3);
  assign word_s      = {rx_data, partial_r};
  assign is_end_s    = (word_s == END_WORD);
  assign wr_next_s   = {1'b0, wr_ptr_r} + ONE_C;
  assign last_slot_s = (wr_next_s == DEPTH_C);
  // rd_ptr runs one ahead of data, so equality means the last word is showing.
  assign burst_end_s = (rd_ptr_r == word_count_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the terminator wins over overflow at the last slot.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_COLLECT: begin
        if (word_done_s && is_end_s) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = S_COLLECT;
        end
      end
      S_LOAD:  state_nxt_s = S_BURST;
      S_BURST: begin
        if (burst_end_s) begin
          state_nxt_s = S_START;
        end else begin
          state_nxt_s = S_BURST;
        end
      end
      S_START: state_nxt_s = S_RUN;
      S_RUN: begin
        if (ff_done) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE:  state_nxt_s = S_DONE;
      default: state_nxt_s = S_COLLECT;
    endcase
  end

  // Byte assembly, write pointer, word count and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_r   <= 2'd0;
      partial_r    <= 24'h000000;
      wr_ptr_r     <= {ADDR_W{1'b0}};
      word_count_r <= {(ADDR_W + 1){1'b0}};
      overflow_r   <= 1'b0;
    end else if (word_done_s) begin
      byte_idx_r <= 2'd0;
      if (is_end_s) begin
        word_count_r <= wr_next_s;
        overflow_r   <= 1'b0;
        wr_ptr_r     <= wr_next_s[ADDR_W-1:0];
      end else if (last_slot_s) begin
        // Image too large: discard it and start collecting from scratch.
        overflow_r <= 1'b1;
        wr_ptr_r   <= {ADDR_W{1'b0}};
      end else begin
        wr_ptr_r <= wr_next_s[ADDR_W-1:0];
      end
    end else if (accept_s) begin
      byte_idx_r <= byte_idx_r + 2'd1;
      case (byte_idx_r)
        2'd0:    partial_r[7:0]   <= rx_data;
        2'd1:    partial_r[15:8]  <= rx_data;
        2'd2:    partial_r[23:16] <= rx_data;
        default: partial_r        <= partial_r;
      endcase
    end
  end

  // Image buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (word_done_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // Buffer read port doubles as the registered data output; holds after burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r   <= 32'h0000_0000;
      rd_ptr_r <= {(ADDR_W + 1){1'b0}};
    end else begin
      case (state_r)
        S_LOAD: begin
          data_r   <= mem_r[{ADDR_W{1'b0}}];
          rd_ptr_r <= ONE_C;
        end
        S_BURST: begin
          if (!burst_end_s) begin
            data_r   <= mem_r[rd_ptr_r[ADDR_W-1:0]];
            rd_ptr_r <= rd_ptr_r + ONE_C;
          end
        end
        default: begin
          data_r   <= data_r;
          rd_ptr_r <= rd_ptr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_stream_loader.sv
// Self-checking bench for ff_stream_loader: stimulus pushes expected burst
// words into a queue; a negedge monitor pops and compares whenever the DUT
// presents a burst.
module tb_ff_stream_loader;

  localparam logic [31:0] END_W = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        ff_done = 1'b0;
  logic [31:0] data;
  logic        load, start, busy, done, overflow, drop;
  logic [9:0]  word_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  int          wc_q[$];
  bit          mon_active = 1'b0;
  bit          start_due = 1'b0;

  ff_stream_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ff_done(ff_done), .data(data), .load(load),
    .start(start), .busy(busy), .done(done), .word_count(word_count),
    .overflow(overflow), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected words during a burst and checks load/start timing.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      start_due  = 1'b0;
      exp_q.delete();
      wc_q.delete();
    end else begin
      logic [31:0] ew;
      bit          es;
      es = start_due;
      start_due = 1'b0;
      check("start", {31'd0, start}, {31'd0, es});
      if (load) begin
        check("load_expected", {31'd0, (!mon_active && wc_q.size() > 0)}, 32'd1);
        if (wc_q.size() > 0) check("word_count", {22'd0, word_count}, wc_q.pop_front());
        check("busy_load", {31'd0, busy}, 32'd1);
        mon_active = 1'b1;
      end else if (mon_active) begin
        check("busy_burst", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          check("burst_overrun", 32'd1, 32'd0);
          mon_active = 1'b0;
        end else begin
          ew = exp_q.pop_front();
          check("burst_data", data, ew);
          if (ew == END_W) begin
            mon_active = 1'b0;
            start_due  = 1'b1;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit push);
    if (push) exp_q.push_back(w);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  // Offer a byte while the loader is not listening; it must be dropped.
  task automatic poke_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    #1;
    check("drop_pulse", {31'd0, drop}, 32'd1);
    check("rx_ready_low", {31'd0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_start(input int bound);
    int n = 0;
    while (!start && n < bound) begin @(negedge clk); n++; end
    check("start_seen", {31'd0, start}, 32'd1);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin @(negedge clk); n++; end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_data"}, data, 32'd0);
    check({nm, "_ctl"}, {26'd0, load, start, busy, done, overflow, drop}, 32'd0);
    check({nm, "_wc"}, {22'd0, word_count}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ff_done = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_rx_ready", {31'd0, rx_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] w;
    // Reset state
    do_reset();

    // Basic burst
    wc_q.push_back(3);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    exp_q.push_back(32'h0000_0001);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h80, 0); send_byte(8'h80, 0);
    exp_q.push_back(32'h8080_0000);
    send_word(END_W, 0, 1'b1);
    wait_start(50);
    repeat (10) @(negedge clk);
    check("run_hold_done", {31'd0, done}, 32'd0);
    check("run_hold_busy", {31'd0, busy}, 32'd1);
    ff_done = 1'b1;
    @(negedge clk);
    check("done_next", {31'd0, done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("data_hold", data, END_W);
    poke_byte(8'h12);
    poke_byte(8'h34);
    repeat (3) @(negedge clk);
    check("done_sticky", {31'd0, done}, 32'd1);

    // Gap-free burst of 201 words with random byte gaps, drops during burst
    do_reset();
    wc_q.push_back(201);
    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      if (w == END_W) w = w ^ 32'd1;
      send_word(w, $urandom_range(0, 2), 1'b1);
    end
    send_word(END_W, 0, 1'b1);
    for (int i = 0; i < 5; i++) poke_byte(8'hA0 + 8'(i));
    ff_done = 1'b1;
    wait_start(400);
    wait_done(10);

    // Overflow: 512 non-terminators, then END_WORD alone
    do_reset();
    for (int i = 0; i < 512; i++) begin
      send_word(32'(i) + 32'h100, 0, 1'b0);
      if (i == 510) check("ovf_before", {31'd0, overflow}, 32'd0);
    end
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_no_busy", {31'd0, busy}, 32'd0);
    wc_q.push_back(1);
    send_word(END_W, 0, 1'b1);
    wait_start(20);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    ff_done = 1'b1;
    wait_done(10);

    // Terminator at the last slot counts as terminator: full 512-word burst
    do_reset();
    wc_q.push_back(512);
    for (int i = 0; i < 511; i++) send_word(32'h5000_0000 + 32'(i), 0, 1'b1);
    send_word(END_W, 0, 1'b1);
    wait_start(700);
    check("full_no_ovf", {31'd0, overflow}, 32'd0);

    // Reset mid-burst, then a fresh 2-word stream
    do_reset();
    wc_q.push_back(10);
    for (int i = 0; i < 9; i++) send_word(32'hC000_0000 + 32'(i), 0, 1'b1);
    send_word(END_W, 0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    wc_q.push_back(2);
    send_word(32'h1234_5678, 1, 1'b1);
    send_word(END_W, 1, 1'b1);
    wait_start(20);
    check("post_reset_wc", {22'd0, word_count}, 32'd2);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
